// File: rtl/muxn_pkg.sv
// Shared types and helpers for the N-way registered stream multiplexer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package muxn_pkg;

  // Selection mode: explicit select or fair round-robin arbitration
  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mux_mode_e;

  // Width of a channel index, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/muxn_stream_rr_picker.sv
// Round-robin picker: first requester after ptr, wrapping from N-1 to 0.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own load enable.
module rr_picker
  import muxn_pkg::*;
#(
  parameter  int N    = 3,
  localparam int SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt
);

  // Scan from the farthest offset down to ptr+1 so the nearest requester wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    for (int off = N; off >= 1; off--) begin
      if (req[(int'(ptr) + off) % N]) begin
        gnt_valid = 1'b1;
        gnt       = SELW'((int'(ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/muxn_stream.sv
// N-way stream mux with one-entry output buffer; explicit-select or round-robin grant.
// Latency: one cycle from input transfer to out_valid/out_data; one word per cycle sustained.
// Backpressure: out_valid & !out_ready holds the buffer and drops every in_ready.
module muxn_stream
  import muxn_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 3,
  localparam int SELW  = clog2_min1(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      s,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  input  logic                 out_ready,
  output logic                 sel_err
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_src_q,   out_src_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;
  logic             sel_err_q,   sel_err_d;

  logic             load_en;
  logic             s_in_range;
  logic             sel_gnt_valid;
  logic             rr_gnt_valid;
  logic [SELW-1:0]  rr_gnt;
  logic             gnt_valid;
  logic [SELW-1:0]  gnt;
  logic [WIDTH-1:0] gnt_data;
  logic             mode_sel;

  // The buffer can take a word when empty or when it is being drained this cycle
  assign load_en    = !out_valid_q || out_ready;
  assign mode_sel   = (mux_mode_e'(mode) == MODE_SEL);
  assign s_in_range = (int'(s) < N);

  rr_picker #(.N(N)) u_rr_picker (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (rr_gnt_valid),
    .gnt       (rr_gnt)
  );

  // Pick the granted channel from the active mode; an out-of-range select grants nothing
  always_comb begin
    sel_gnt_valid = s_in_range && in_valid[s];
    if (mode_sel) begin
      gnt_valid = sel_gnt_valid;
      gnt       = sel_gnt_valid ? s : '0;
    end else begin
      gnt_valid = rr_gnt_valid;
      gnt       = rr_gnt;
    end
    gnt_data = in_data[int'(gnt)*WIDTH +: WIDTH];
  end

  // One-hot ready to the granted channel; forced low while reset is held
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !reset && load_en && gnt_valid && (int'(gnt) == i);
    end
  end

  // Next state: refill on grant, empty on idle load, hold under backpressure
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    sel_err_d   = load_en && mode_sel && !s_in_range;
    if (load_en) begin
      if (gnt_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = gnt_data;
        out_src_d   = gnt;
        rr_ptr_d    = gnt;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; rr_ptr resets to N-1 so the first round-robin grant is channel 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= SELW'(N - 1);
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_muxn_stream.sv
// Bench for muxn_stream (N=3, WIDTH=8): directed scenarios then random traffic against a reference model.
// Latency: checks registered outputs one cycle after each modelled transfer.
// Backpressure: random out_ready exercises hold and same-edge drain/refill.
module tb_muxn_stream;

  localparam int N     = 3;
  localparam int WIDTH = 8;
  localparam int SELW  = 2;

  logic                 clk;
  logic                 reset;
  logic                 mode;
  logic [SELW-1:0]      s;
  logic [N-1:0]         in_valid;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_src;
  logic                 out_ready;
  logic                 sel_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit             m_vld;
  logic [WIDTH-1:0] m_data;
  int             m_src;
  int             m_ptr;
  bit             m_err;

  muxn_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .s         (s),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant from the rules: select index if valid, else first valid after the pointer
  function automatic int model_grant(input logic md, input int sel, input logic [N-1:0] v, input int ptr);
    if (md == 1'b0) begin
      if (sel < N && v[sel]) return sel;
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld  = 0;
    m_data = '0;
    m_src  = 0;
    m_ptr  = N - 1;
    m_err  = 0;
  endtask

  // One clock: compare outputs against the model before the edge, then advance the model
  task automatic cycle();
    bit le;
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    le = !m_vld || out_ready;
    g  = model_grant(mode, int'(s), in_valid, m_ptr);
    exp_rdy = '0;
    if (le && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_vld));
    if (m_vld) begin
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_src", 32'(out_src), 32'(m_src));
    end
    check("sel_err", 32'(sel_err), 32'(m_err));
    @(posedge clk);
    m_err = le && (mode == 1'b0) && (int'(s) >= N);
    if (le) begin
      if (g >= 0) begin
        m_vld  = 1;
        m_data = in_data[g*WIDTH +: WIDTH];
        m_src  = g;
        m_ptr  = g;
      end else begin
        m_vld = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] held_data;
    logic [SELW-1:0]  held_src;

    reset     = 1'b1;
    mode      = 1'b0;
    s         = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Explicit select of channel 2
    mode = 1'b0; s = 2'd2; in_valid = 3'b111;
    in_data = {8'hC2, 8'hB1, 8'hA0}; out_ready = 1'b1;
    #1;
    check("sel2_in_ready", 32'(in_ready), 32'b100);
    cycle();
    check("sel2_out_valid", 32'(out_valid), 32'd1);
    check("sel2_out_data", 32'(out_data), 32'hC2);
    check("sel2_out_src", 32'(out_src), 32'd2);

    // Round-robin from reset, all channels valid
    do_reset();
    mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_seq_src", 32'(out_src), 32'(k % 3));
      check("rr_seq_valid", 32'(out_valid), 32'd1);
    end

    // Wrap-around with channel 1 idle, starting from pointer 0
    do_reset();
    mode = 1'b1; in_valid = 3'b001; out_ready = 1'b1;
    cycle();
    check("wrap_prime_src", 32'(out_src), 32'd0);
    in_valid = 3'b101;
    cycle();
    check("wrap_src_a", 32'(out_src), 32'd2);
    cycle();
    check("wrap_src_b", 32'(out_src), 32'd0);
    cycle();
    check("wrap_src_c", 32'(out_src), 32'd2);

    // Backpressure hold then same-edge drain and refill
    in_data = {8'h33, 8'h22, 8'h11};
    in_valid = 3'b111;
    cycle();
    held_data = out_data;
    held_src  = out_src;
    out_ready = 1'b0;
    in_data = {8'h66, 8'h55, 8'h44};
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_hold_data", 32'(out_data), 32'(held_data));
      check("bp_hold_src", 32'(out_src), 32'(held_src));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_refill_valid", 32'(out_valid), 32'd1);
    check("bp_refill_src", 32'(out_src), 32'((int'(held_src) + 1) % N));

    // Out-of-range select with an empty buffer
    in_valid = 3'b000;
    cycle();
    check("oor_empty", 32'(out_valid), 32'd0);
    mode = 1'b0; s = 2'd3; in_valid = 3'b111;
    #1;
    check("oor_in_ready", 32'(in_ready), 32'd0);
    cycle();
    check("oor_sel_err", 32'(sel_err), 32'd1);
    check("oor_out_valid", 32'(out_valid), 32'd0);
    s = 2'd0; in_valid = 3'b000;
    cycle();
    check("oor_sel_err_clr", 32'(sel_err), 32'd0);

    // Asynchronous reset while a word is stalled
    mode = 1'b1; in_valid = 3'b111; in_data = {8'h99, 8'h88, 8'h77}; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("arst_first_rr", 32'(in_ready), 32'b001);
    cycle();
    check("arst_first_src", 32'(out_src), 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      mode      = 1'($urandom_range(0, 1));
      s         = SELW'($urandom_range(0, 3));
      in_valid  = N'($urandom);
      in_data   = (N*WIDTH)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
